// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: owner-state encoding and
// default port widths.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Owner of the memory port in the previous cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        FGRANT = 2'd2,
        LOCK   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Fetch starvation counter: counts data grants taken while fetch is waiting
// and raises trip when fetch must be let through.
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic f_req,
    input  logic f_gnt,
    input  logic d_gnt,
    input  logic in_lock,
    output logic trip
);

    localparam int CNT_W = 4;

    logic [CNT_W-1:0] cnt;

    // Count data grants while fetch waits; any fetch grant or a dropped fetch
    // request starts the count over. Saturates so a long lock cannot wrap it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!f_req || f_gnt) begin
            cnt <= '0;
        end else if (d_gnt && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A locked sequence is never interrupted, so the trip is masked in LOCK.
    assign trip = (cnt == CNT_W'(STARVE_MAX)) && !in_lock;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between an instruction-fetch requester and a
// data requester. Data has priority; a locked data sequence owns the port.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN -- when defined, fetch is
// granted over data after STARVE_MAX consecutive data grants while it waits.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state, state_nxt;
    logic       in_lock;
    logic       starve_trip;
    logic       f_win, d_win;
    logic       f_rd_q, d_rd_q;

    assign in_lock = (state == LOCK);

`ifdef MEM_ARB_STARVE_GUARD_EN
    arb_starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .f_req  (f_req),
        .f_gnt  (f_gnt),
        .d_gnt  (d_gnt),
        .in_lock(in_lock),
        .trip   (starve_trip)
    );
`else
    // Strict data priority: STARVE_MAX is 1..15, so this is always 0 and the
    // parameter stays part of the interface for builds with the guard.
    assign starve_trip = (STARVE_MAX == 0);
`endif

    // Arbitration and owner-tracking next state; grants are masked in reset.
    always_comb begin
        f_win     = f_req && !in_lock && (!d_req || starve_trip);
        d_win     = d_req && !f_win;
        f_gnt     = f_win && !reset;
        d_gnt     = d_win && !reset;
        state_nxt = IDLE;
        if (d_gnt && d_lock) begin
            state_nxt = LOCK;
        end else if (d_gnt) begin
            state_nxt = DGRANT;
        end else if (f_gnt) begin
            state_nxt = FGRANT;
        end
    end

    // Owner state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read-response tags: memory returns data one cycle after a read issues.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_rd_q <= 1'b0;
            d_rd_q <= 1'b0;
        end else begin
            f_rd_q <= f_gnt;
            d_rd_q <= d_gnt && !d_we;
        end
    end

    assign f_rvalid  = f_rd_q;
    assign d_rvalid  = d_rd_q;
    assign f_rdata   = f_rd_q ? mem_rdata : '0;
    assign d_rdata   = d_rd_q ? mem_rdata : '0;

    assign stall     = d_req && !d_gnt;
    assign mem_en    = f_gnt || d_gnt;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = d_gnt ? d_addr : (f_gnt ? f_addr : '0);
    assign mem_wdata = d_gnt ? d_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a cycle table of requests and
// expected grants, a response scoreboard, and hand sequences for reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, d_req, d_we, d_lock;
    logic [15:0] f_addr, d_addr, d_wdata, mem_rdata;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid, stall, mem_en, mem_we;
    logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        f_req;
        logic [15:0] f_addr;
        logic        d_req, d_we, d_lock;
        logic [15:0] d_addr, d_wdata;
        logic        e_f, e_d, e_stall;
        logic [15:0] e_addr;
        logic        e_we;
    } vec_t;

    typedef struct {
        int          due;
        bit          is_f;
        logic [15:0] data;
    } rsp_t;

    vec_t tab_a[15];
    vec_t tab_b[9];
    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic vec_t mk(logic fr, logic [15:0] fa, logic dr, logic dwe,
                                logic dl, logic [15:0] da, logic [15:0] dwd,
                                logic ef, logic ed, logic es, logic [15:0] ea,
                                logic ewe);
        vec_t v;
        v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_we = dwe; v.d_lock = dl;
        v.d_addr = da; v.d_wdata = dwd; v.e_f = ef; v.e_d = ed; v.e_stall = es;
        v.e_addr = ea; v.e_we = ewe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_lock = 0;
        d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    // One table row = one clock cycle: drive at negedge, compare 1 ns later.
    task automatic apply(input vec_t v, input string tag);
        rsp_t r;
        @(negedge clk);
        f_req = v.f_req; f_addr = v.f_addr; d_req = v.d_req; d_we = v.d_we;
        d_lock = v.d_lock; d_addr = v.d_addr; d_wdata = v.d_wdata;
        mem_rdata = 16'(32'h1000 + cyc);
        #1;
        chk({tag, ".f_gnt"}, 32'(f_gnt), 32'(v.e_f));
        chk({tag, ".d_gnt"}, 32'(d_gnt), 32'(v.e_d));
        chk({tag, ".stall"}, 32'(stall), 32'(v.e_stall));
        chk({tag, ".mem_en"}, 32'(mem_en), 32'(v.e_f | v.e_d));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(v.e_we));
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), v.e_d ? 32'(v.d_wdata) : 32'h0);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            chk({tag, ".f_rvalid"}, 32'(f_rvalid), 32'(r.is_f));
            chk({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(!r.is_f));
            chk({tag, ".f_rdata"}, 32'(f_rdata), r.is_f ? 32'(r.data) : 32'h0);
            chk({tag, ".d_rdata"}, 32'(d_rdata), r.is_f ? 32'h0 : 32'(r.data));
        end else begin
            chk({tag, ".f_rvalid"}, 32'(f_rvalid), 32'h0);
            chk({tag, ".d_rvalid"}, 32'(d_rvalid), 32'h0);
            chk({tag, ".f_rdata"}, 32'(f_rdata), 32'h0);
            chk({tag, ".d_rdata"}, 32'(d_rdata), 32'h0);
        end
        if (v.e_f)
            sb.push_back('{cyc + 1, 1'b1, 16'(32'h1000 + cyc + 1)});
        else if (v.e_d && !v.d_we)
            sb.push_back('{cyc + 1, 1'b0, 16'(32'h1000 + cyc + 1)});
        cyc++;
    endtask

    initial begin
        // Mixed traffic, lock behaviour and back-to-back owners.
        tab_a[0]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
        tab_a[1]  = mk(1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0010, 0);
        tab_a[2]  = mk(1, 16'h0012, 1, 0, 0, 16'h0200, 16'h0000, 0, 1, 0, 16'h0200, 0);
        tab_a[3]  = mk(1, 16'h0012, 1, 1, 0, 16'h0300, 16'hBEEF, 0, 1, 0, 16'h0300, 1);
        tab_a[4]  = mk(1, 16'h0012, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0012, 0);
        tab_a[5]  = mk(1, 16'h0014, 1, 0, 1, 16'h0400, 16'h0000, 0, 1, 0, 16'h0400, 0);
        tab_a[6]  = mk(1, 16'h0014, 1, 1, 1, 16'h03FF, 16'h1234, 0, 1, 0, 16'h03FF, 1);
        tab_a[7]  = mk(1, 16'h0014, 1, 0, 0, 16'h03FF, 16'h0000, 0, 1, 0, 16'h03FF, 0);
        tab_a[8]  = mk(1, 16'h0014, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0014, 0);
        tab_a[9]  = mk(1, 16'h0016, 1, 0, 1, 16'h0500, 16'h0000, 0, 1, 0, 16'h0500, 0);
        tab_a[10] = mk(1, 16'h0016, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
        tab_a[11] = mk(1, 16'h0016, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0016, 0);
        tab_a[12] = mk(0, 16'h0000, 1, 0, 0, 16'h0600, 16'h0000, 0, 1, 0, 16'h0600, 0);
        tab_a[13] = mk(0, 16'h0000, 1, 1, 0, 16'h0602, 16'h5A5A, 0, 1, 0, 16'h0602, 1);
        tab_a[14] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
        // Both requesters held continuously from a fresh reset.
        for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (k == 4)
                tab_b[k] = mk(1, 16'h0020, 1, 0, 0, 16'(16'h0700 + k), 16'h0000,
                              1, 0, 1, 16'h0020, 0);
            else
`endif
                tab_b[k] = mk(1, 16'h0020, 1, 0, 0, 16'(16'h0700 + k), 16'h0000,
                              0, 1, 0, 16'(16'h0700 + k), 0);
        end
        tab_b[8] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);

        // Reset state: requests present, everything forced quiet.
        reset = 1'b1;
        drive_idle();
        f_req = 1; d_req = 1; f_addr = 16'h0010; d_addr = 16'h0200;
        mem_rdata = 16'h0;
        #1;
        chk("rst.f_gnt", 32'(f_gnt), 32'h0);
        chk("rst.d_gnt", 32'(d_gnt), 32'h0);
        chk("rst.mem_en", 32'(mem_en), 32'h0);
        chk("rst.mem_addr", 32'(mem_addr), 32'h0);
        chk("rst.stall", 32'(stall), 32'h1);
        chk("rst.f_rvalid", 32'(f_rvalid), 32'h0);
        chk("rst.d_rvalid", 32'(d_rvalid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();

        for (int i = 0; i < 15; i++) apply(tab_a[i], $sformatf("A%0d", i));
        do_reset();
        for (int i = 0; i < 9; i++) apply(tab_b[i], $sformatf("B%0d", i));

        // Read granted, then reset asserted before the edge: no response.
        @(negedge clk);
        drive_idle();
        f_req = 1; f_addr = 16'h0030; mem_rdata = 16'h7777;
        #1;
        chk("rs_same.f_gnt_pre", 32'(f_gnt), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("rs_same.f_gnt_rst", 32'(f_gnt), 32'h0);
        chk("rs_same.mem_en_rst", 32'(mem_en), 32'h0);
        @(posedge clk);
        #1;
        chk("rs_same.f_rvalid", 32'(f_rvalid), 32'h0);
        chk("rs_same.f_rdata", 32'(f_rdata), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();

        // Locked read completes, reset mid-cycle kills the response at once.
        @(negedge clk);
        d_req = 1; d_lock = 1; d_we = 0; d_addr = 16'h0800;
        f_req = 1; f_addr = 16'h0040;
        #1;
        chk("rs_mid.d_gnt", 32'(d_gnt), 32'h1);
        chk("rs_mid.f_gnt", 32'(f_gnt), 32'h0);
        @(posedge clk);
        #1 mem_rdata = 16'hCAFE;
        #1;
        chk("rs_mid.d_rvalid_pre", 32'(d_rvalid), 32'h1);
        chk("rs_mid.d_rdata_pre", 32'(d_rdata), 32'hCAFE);
        #1 reset = 1'b1;
        #1;
        chk("rs_mid.d_rvalid_rst", 32'(d_rvalid), 32'h0);
        chk("rs_mid.d_rdata_rst", 32'(d_rdata), 32'h0);
        chk("rs_mid.f_rvalid_rst", 32'(f_rvalid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        d_req = 0; d_lock = 0;
        #1;
        chk("rs_mid.f_gnt_idle", 32'(f_gnt), 32'h1);
        chk("rs_mid.d_rvalid_rel", 32'(d_rvalid), 32'h0);
        @(posedge clk);
        #1;
        chk("rs_mid.d_rvalid_after", 32'(d_rvalid), 32'h0);
        chk("rs_mid.f_rvalid_after", 32'(f_rvalid), 32'h1);
        chk("rs_mid.f_rdata_after", 32'(f_rdata), 32'hCAFE);
        @(negedge clk);
        drive_idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
